// File: rtl/uart_tx_model_if.sv
// uart_tx_model_if: valid/ready byte push channel into the UART transmitter FIFO
interface uart_tx_model_if #(parameter int W = 8) ();
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_model.sv
// uart_tx_model: FIFO-buffered UART transmitter (start, LSB-first payload, stop bits)
module uart_tx_model #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          tx_en,
  uart_tx_model_if.slave                bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          uart_txd
);
  localparam int CPB  = CLK_HZ / BIT_RATE;
  localparam int CW   = $clog2(STOP_BITS * CPB);
  localparam int BW   = PAYLOAD_BITS > 1 ? $clog2(PAYLOAD_BITS) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                  state, state_d;
  logic [CW-1:0]           cyc_cnt, cyc_d;
  logic [BW-1:0]           bit_idx, bit_d;
  logic [PAYLOAD_BITS-1:0] shift;
  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    push, pop, txd_d, bit_end, can_pop;
  assign bus.tx_ready = fifo_count != CNTW'(FIFO_DEPTH);
  assign push         = bus.tx_valid && bus.tx_ready;
  assign can_pop      = tx_en && fifo_count != '0;
  assign bit_end      = cyc_cnt == CW'(CPB - 1);
  assign tx_busy      = state != IDLE;
  always_comb begin
    state_d = state;
    cyc_d   = bit_end ? '0 : cyc_cnt + CW'(1);
    bit_d   = bit_idx;
    pop     = 1'b0;
    txd_d   = state == START ? 1'b0 : state == DATA ? shift[bit_idx] : 1'b1;
    case (state)
      IDLE: begin
        cyc_d = '0;
        if (can_pop) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        bit_d   = bit_idx + BW'(1);
        state_d = bit_idx == BW'(PAYLOAD_BITS - 1) ? STOP : DATA;
      end
      default: begin
        // stop phase spans all stop bits in one count; chain straight into the next frame
        cyc_d = cyc_cnt + CW'(1);
        if (cyc_cnt == CW'(STOP_BITS * CPB - 1)) begin
          cyc_d   = '0;
          pop     = can_pop;
          state_d = can_pop ? START : IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      uart_txd   <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state      <= state_d;
      cyc_cnt    <= cyc_d;
      bit_idx    <= bit_d;
      uart_txd   <= txd_d;
      fifo_count <= fifo_count + CNTW'(push) - CNTW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        shift  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end
endmodule

// File: tb/tb_uart_tx_model.sv
// tb_uart_tx_model: random and directed checks of uart_tx_model against a line-level frame model
module tb_uart_tx_model;
  logic clk = 0, resetn = 1, en_a = 0, en_b = 0;
  logic [4:0] fifo_a, fifo_b;
  logic busy_a, busy_b, txd_a, txd_b;
  int n_chk = 0, n_pass = 0, cyc = 0, rst_epoch = 0;
  logic [7:0] sent_q[$], rx_q[$];
  int st_q[$];
  uart_tx_model_if #(.W(8)) ifa ();
  uart_tx_model_if #(.W(8)) ifb ();
  uart_tx_model #(.BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16))
    dut_a (.clk(clk), .resetn(resetn), .tx_en(en_a), .bus(ifa), .fifo_count(fifo_a), .tx_busy(busy_a), .uart_txd(txd_a));
  uart_tx_model #(.BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(16))
    dut_b (.clk(clk), .resetn(resetn), .tx_en(en_b), .bus(ifb), .fifo_count(fifo_b), .tx_busy(busy_b), .uart_txd(txd_b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ideal 8N1 line level k cycles after the start bit begins
  function automatic logic exp_line(input logic [7:0] b, input int k);
    return k < 10 ? 1'b0 : k < 90 ? b[(k - 10) / 10] : 1'b1;
  endfunction

  task automatic push_byte(input bit sel, input logic [7:0] b);
    int g = 0;
    if (sel) begin ifb.tx_data = b; ifb.tx_valid = 1; end
    else begin ifa.tx_data = b; ifa.tx_valid = 1; end
    while (!(sel ? ifb.tx_ready : ifa.tx_ready) && g < 3000) begin @(posedge clk); #1; g++; end
    if (!(sel ? ifb.tx_ready : ifa.tx_ready)) chk("push_ready", 0, 1);
    else begin
      @(posedge clk); #1;
      if (!sel) sent_q.push_back(b);
    end
    ifa.tx_valid = 0;
    ifb.tx_valid = 0;
  endtask

  task automatic frame_check(input bit sel, input logic [7:0] b, input int stops, input string tag);
    int len = 10 * (9 + stops), errs = 0, busy_n = 0;
    logic t, bz, e;
    push_byte(sel, b);
    for (int j = 0; j < len + 4; j++) begin
      @(negedge clk);
      t  = sel ? txd_b : txd_a;
      bz = sel ? busy_b : busy_a;
      e  = (j >= 2 && j < len + 2) ? exp_line(b, j - 2) : 1'b1;
      if (t !== e || bz !== (j >= 1 && j <= len)) errs++;
      if (bz === 1'b1) busy_n++;
    end
    chk({tag, "_wave"}, errs, 0);
    chk({tag, "_busy_len"}, busy_n, len);
  endtask

  task automatic drain_check(input string tag);
    int g = 0;
    while ((busy_a || fifo_a != 0) && g < 30000) begin @(negedge clk); g++; end
    chk({tag, "_idle"}, busy_a, 0);
    repeat (20) @(negedge clk);
    chk({tag, "_nrx"}, rx_q.size(), sent_q.size());
    for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++) chk({tag, "_byte"}, rx_q[i], sent_q[i]);
    sent_q.delete();
    rx_q.delete();
  endtask

  // line decoder on dut_a: samples mid-bit, drops frames cut by a reset
  initial begin
    int ep, t0;
    logic [7:0] rb;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && txd_a === 1'b0) begin
        ep = rst_epoch;
        t0 = cyc;
        if (st_q.size() > 0) chk("frame_gap", (t0 - st_q[$]) >= 100, 1);
        st_q.push_back(t0);
        repeat (4) @(negedge clk);
        if (ep == rst_epoch) chk("start_bit", txd_a, 0);
        for (int i = 0; i < 8; i++) begin repeat (10) @(negedge clk); rb[i] = txd_a; end
        repeat (10) @(negedge clk);
        if (ep == rst_epoch) begin
          chk("stop_bit", txd_a, 1);
          rx_q.push_back(rb);
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n0, errs;
    logic [7:0] b17;
    ifa.tx_valid = 0; ifa.tx_data = 0;
    ifb.tx_valid = 0; ifb.tx_data = 0;
    #3 resetn = 0;
    repeat (2) @(negedge clk);
    chk("rst_txd", txd_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_count", fifo_a, 0);
    chk("rst_ready", ifa.tx_ready, 1);
    chk("rst_txd_b", txd_b, 1);
    @(posedge clk); #1 resetn = 1;
    repeat (3) begin @(posedge clk); #1; end
    en_a = 1;
    en_b = 1;
    // T1: single frame, exact latency and waveform
    frame_check(0, 8'h55, 1, "t1");
    drain_check("t1");
    // T2: back-to-back frames with no idle gap
    st_q.delete();
    push_byte(0, 8'h41);
    push_byte(0, 8'h0A);
    drain_check("t2");
    chk("t2_starts", st_q.size(), 2);
    if (st_q.size() == 2) chk("t2_gap", st_q[1] - st_q[0], 100);
    st_q.delete();
    // T3: fill while disabled, then release
    en_a = 0;
    for (int i = 0; i < 16; i++) push_byte(0, 8'($urandom));
    b17 = 8'($urandom);
    ifa.tx_data = b17;
    ifa.tx_valid = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("t3_ready", ifa.tx_ready, 0);
    chk("t3_count", fifo_a, 16);
    chk("t3_txd", txd_a, 1);
    chk("t3_busy", busy_a, 0);
    en_a = 1;
    @(posedge clk); #1;
    chk("t3_ready_rise", ifa.tx_ready, 1);
    chk("t3_count_pop", fifo_a, 15);
    @(posedge clk); #1;
    ifa.tx_valid = 0;
    sent_q.push_back(b17);
    chk("t3_refill", fifo_a, 16);
    drain_check("t3");
    st_q.delete();
    // T4: disable during data bit 3
    push_byte(0, 8'hC3);
    n0 = cyc;
    push_byte(0, 8'($urandom));
    push_byte(0, 8'($urandom));
    while (cyc < n0 + 45) begin @(posedge clk); #1; end
    en_a = 0;
    repeat (80) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("t4_busy", busy_a, 0);
    chk("t4_txd", txd_a, 1);
    chk("t4_count", fifo_a, 2);
    chk("t4_nrx", rx_q.size(), 1);
    repeat (50) @(negedge clk);
    chk("t4_hold_txd", txd_a, 1);
    chk("t4_hold_count", fifo_a, 2);
    en_a = 1;
    drain_check("t4");
    st_q.delete();
    // T5: asynchronous reset during data bit 5
    push_byte(0, 8'h0F);
    n0 = cyc;
    push_byte(0, 8'hAA);
    while (cyc < n0 + 67) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("t5_pre_txd", txd_a, 0);
    #1 rst_epoch++;
    resetn = 0;
    #1;
    chk("t5_txd", txd_a, 1);
    chk("t5_busy", busy_a, 0);
    chk("t5_count", fifo_a, 0);
    chk("t5_ready", ifa.tx_ready, 1);
    repeat (3) begin @(posedge clk); #1; end
    resetn = 1;
    sent_q.delete();
    errs = 0;
    repeat (150) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a !== 1'b0 || fifo_a !== 5'd0) errs++;
    end
    chk("t5_idle_after", errs, 0);
    rx_q.delete();
    st_q.delete();
    // T6: two stop bits on dut_b
    frame_check(1, 8'hFF, 2, "t6");
    // random traffic with gaps and enable pauses
    for (int i = 0; i < 24; i++) begin
      push_byte(0, 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(50, 150)) begin @(posedge clk); #1; end
      if ($urandom_range(0, 4) == 0) begin
        en_a = 0;
        repeat ($urandom_range(20, 200)) begin @(posedge clk); #1; end
        en_a = 1;
      end
    end
    drain_check("rand");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
